udp_cmd_parser: RTL and testbench

//  Sits directly downstream of udp_cmd_fifo (sync, 33-bit, depth 64, no output reg) and drains it.

---
 rtl/udp_cmd_pkg.sv | 34 +++
 rtl/udp_cmd_word_buf.sv | 49 ++++
 rtl/udp_cmd_parser.sv | 245 ++++++++++++++++++++++++
 tb/tb_udp_cmd_parser.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_cmd_pkg.sv
// ============================================================================
// Module : udp_cmd_pkg
// Brief  : Shared opcodes, header field positions and FSM states for the
//          UDP command parser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package udp_cmd_pkg;

    localparam logic [3:0]  OP_WRITE    = 4'd1;
    localparam logic [3:0]  OP_READ     = 4'd2;
    localparam int          HDR_OP_MSB  = 31;
    localparam int          HDR_OP_LSB  = 28;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WDATA   = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RESP    = 3'd6,
        ST_DROP    = 3'd7
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_cmd_word_buf.sv
// ============================================================================
// Module : udp_cmd_word_buf
// Brief  : Single-outstanding pop from a latency-1 FIFO into a one-word buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module udp_cmd_word_buf #(
    parameter int WORD_W = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_want,
    input  logic              i_consume,
    input  logic              i_fifo_empty,
    input  logic [WORD_W-1:0] i_fifo_rd_data,
    output logic              o_fifo_rd_en,
    output logic [WORD_W-1:0] o_wbuf,
    output logic              o_wbuf_valid
);

    logic              r_pend;
    logic [WORD_W-1:0] r_wbuf;
    logic              r_wbuf_valid;

    assign o_fifo_rd_en = !i_fifo_empty && !r_pend && !r_wbuf_valid && i_want;
    assign o_wbuf       = r_wbuf;
    assign o_wbuf_valid = r_wbuf_valid;

    // FIFO data appears the cycle after the pop; capture it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= 1'b0;
            r_wbuf       <= '0;
            r_wbuf_valid <= 1'b0;
        end else begin
            r_pend <= o_fifo_rd_en;
            if (r_pend) begin
                r_wbuf       <= i_fifo_rd_data;
                r_wbuf_valid <= 1'b1;
            end else if (i_consume) begin
                r_wbuf_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/udp_cmd_parser.sv
// ============================================================================
// Module : udp_cmd_parser
// Brief  : Decodes command frames from udp_cmd_fifo into register-bus bursts
//          and streams read results back as response frames.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module udp_cmd_parser
    import udp_cmd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_LEN    = 256,
    parameter int ADDR_INC   = 1,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DATA_W:0]   fifo_rd_data,
    input  logic              fifo_empty,
    output logic              bus_wr_en,
    output logic              bus_rd_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    input  logic              resp_ready,
    output logic [15:0]       err_cnt
);

    localparam int                IDX_W      = LEN_W + 1;
    localparam int                TMO_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_INC = ADDR_W'(ADDR_INC);
    localparam logic [IDX_W-1:0]  c_MAX_LEN  = IDX_W'(MAX_LEN);
    localparam logic [DATA_W-1:0] c_ERR_DATA = DATA_W'(RD_ERR_DATA);

    state_t             r_state;
    logic [DATA_W-1:0]  r_hdr;
    logic [3:0]         r_op;
    logic [LEN_W-1:0]   r_len;
    logic [IDX_W-1:0]   r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_hdr_sent;
    logic               r_bus_wr_en;
    logic               r_bus_rd_en;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wdata;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_resp_last;
    logic [15:0]        r_err_cnt;

    logic               w_want;
    logic               w_consume;
    logic [DATA_W:0]    w_wbuf;
    logic               w_wbuf_valid;
    logic               w_word_last;
    logic [DATA_W-1:0]  w_payload;
    logic [3:0]         w_opcode;
    logic [LEN_W-1:0]   w_len;
    logic               w_hdr_bad;
    logic [IDX_W-1:0]   w_last_idx;
    logic               w_at_last;
    logic [DATA_W-1:0]  w_rd_word;

    udp_cmd_word_buf #(
        .WORD_W (DATA_W + 1)
    ) u_word_buf (
        .clk            (clk),
        .rst            (rst),
        .i_want         (w_want),
        .i_consume      (w_consume),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_rd_data (fifo_rd_data),
        .o_fifo_rd_en   (fifo_rd_en),
        .o_wbuf         (w_wbuf),
        .o_wbuf_valid   (w_wbuf_valid)
    );

    assign w_word_last = w_wbuf[DATA_W];
    assign w_payload   = w_wbuf[DATA_W-1:0];
    assign w_opcode    = w_payload[HDR_OP_MSB:HDR_OP_LSB];
    assign w_len       = w_payload[LEN_W-1:0];
    assign w_hdr_bad   = ((w_opcode != OP_WRITE) && (w_opcode != OP_READ)) ||
                         (w_len == '0) || ({1'b0, w_len} > c_MAX_LEN) || w_word_last;
    assign w_last_idx  = {1'b0, r_len} - IDX_W'(1);
    assign w_at_last   = (r_idx == w_last_idx);
    // rvalid wins over a coincident timeout.
    assign w_rd_word   = bus_rvalid ? bus_rdata : c_ERR_DATA;

    // No prefetch while a write is held, so a following frame is never pulled early.
    always_comb begin
        w_want = 1'b0;
        case (r_state)
            ST_HDR, ST_ADDR, ST_DROP: w_want = 1'b1;
            ST_WDATA:                 w_want = !r_bus_wr_en;
            default:                  w_want = 1'b0;
        endcase
        w_consume = w_want && w_wbuf_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hdr        <= '0;
            r_op         <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_rd_data    <= '0;
            r_hdr_sent   <= 1'b0;
            r_bus_wr_en  <= 1'b0;
            r_bus_rd_en  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_last  <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_wbuf_valid) begin
                        r_hdr <= w_payload;
                        r_op  <= w_opcode;
                        r_len <= w_len;
                        if (w_hdr_bad) begin
                            r_err_cnt <= sat_inc16(r_err_cnt);
                            r_state   <= w_word_last ? ST_IDLE : ST_DROP;
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_wbuf_valid) begin
                        r_bus_addr <= ADDR_W'(w_payload);
                        r_idx      <= '0;
                        r_hdr_sent <= 1'b0;
                        if ((r_op == OP_WRITE) == w_word_last) begin
                            r_err_cnt <= sat_inc16(r_err_cnt);
                            r_state   <= w_word_last ? ST_IDLE : ST_DROP;
                        end else if (r_op == OP_WRITE) begin
                            r_state <= ST_WDATA;
                        end else begin
                            r_bus_rd_en <= 1'b1;
                            r_state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_WDATA: begin
                    if (r_bus_wr_en) begin
                        if (bus_ready) begin
                            r_bus_wr_en <= 1'b0;
                            r_bus_addr  <= r_bus_addr + c_ADDR_INC;
                            r_idx       <= r_idx + IDX_W'(1);
                            if (w_at_last) r_state <= ST_IDLE;
                        end
                    end else if (w_wbuf_valid) begin
                        // A misplaced or missing LAST aborts before this word is written.
                        if (w_word_last != w_at_last) begin
                            r_err_cnt <= sat_inc16(r_err_cnt);
                            r_state   <= w_word_last ? ST_IDLE : ST_DROP;
                        end else begin
                            r_bus_wr_en <= 1'b1;
                            r_bus_wdata <= w_payload;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (bus_ready) begin
                        r_bus_rd_en <= 1'b0;
                        r_bus_addr  <= r_bus_addr + c_ADDR_INC;
                        r_tmo       <= '0;
                        r_state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus_rvalid || (r_tmo == c_TMO_LAST)) begin
                        if (!bus_rvalid) r_err_cnt <= sat_inc16(r_err_cnt);
                        r_rd_data    <= w_rd_word;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                        if (!r_hdr_sent) begin
                            r_resp_data <= r_hdr;
                            r_resp_last <= 1'b0;
                        end else begin
                            r_resp_data <= w_rd_word;
                            r_resp_last <= w_at_last;
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (r_resp_valid && resp_ready) begin
                        if (!r_hdr_sent) begin
                            r_hdr_sent  <= 1'b1;
                            r_resp_data <= r_rd_data;
                            r_resp_last <= w_at_last;
                        end else begin
                            r_resp_valid <= 1'b0;
                            r_resp_last  <= 1'b0;
                            r_idx        <= r_idx + IDX_W'(1);
                            if (w_at_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_bus_rd_en <= 1'b1;
                                r_state     <= ST_RD_REQ;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_wbuf_valid && w_word_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_wr_en  = r_bus_wr_en;
    assign bus_rd_en  = r_bus_rd_en;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_last  = r_resp_last;
    assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_udp_cmd_parser.sv
// ============================================================================
// Module : tb_udp_cmd_parser
// Brief  : Scoreboard bench for udp_cmd_parser with FIFO and bus slave models.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_udp_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd_en;
    logic [32:0] fifo_rd_data = '0;
    logic        fifo_empty;
    logic        bus_wr_en, bus_rd_en;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready = 1'b1;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;
    logic        resp_valid, resp_last;
    logic [31:0] resp_data;
    logic        resp_ready = 1'b1;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] fmem [0:1023];
    int          fwr  = 0;
    int          frd  = 0;
    int          pops = 0;

    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [32:0] exp_resp[$];
    logic [31:0] rd_q[$];

    logic        rd_mute = 1'b0;
    int          rd_lat  = 3;
    logic        resp_toggle = 1'b0;
    logic        rd_pend = 1'b0;
    int          rd_cnt  = 0;

    logic        pv_wr = 1'b0, pv_rd = 1'b0, pv_resp = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, p_rdata = '0;
    logic        p_last = 1'b0;

    udp_cmd_parser dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .bus_wr_en    (bus_wr_en),
        .bus_rd_en    (bus_rd_en),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_rvalid   (bus_rvalid),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_last    (resp_last),
        .resp_ready   (resp_ready),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fwr == frd);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[frd];
            frd          <= frd + 1;
            pops         <= pops + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic last, input logic [31:0] d);
        fmem[fwr] = {last, d};
        fwr = fwr + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {fifo_rd_en, bus_wr_en, bus_rd_en, resp_valid, resp_last}, 0);
        chk({tag, "_addr"}, bus_addr, 0);
        chk({tag, "_wdata"}, bus_wdata, 0);
        chk({tag, "_rdata"}, resp_data, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            tick(1);
            if (fifo_empty && exp_wr.size() == 0 && exp_rd.size() == 0 &&
                exp_resp.size() == 0 && !bus_wr_en && !bus_rd_en && !resp_valid)
                break;
        end
        if (c == budget) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required completion", tag, budget);
        end
        tick(8);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = resp_toggle ? ~resp_ready : 1'b1;
    end

    // Monitor and bus slave: sample mid-cycle, scoreboard-compare on handshakes.
    always @(negedge clk) begin
        if (rst) begin
            pv_wr      <= 1'b0;
            pv_rd      <= 1'b0;
            pv_resp    <= 1'b0;
            rd_pend    <= 1'b0;
            bus_rvalid <= 1'b0;
        end else begin
            if (pv_wr) begin
                chk("wr_hold_en", bus_wr_en, 1);
                chk("wr_hold_bus", {bus_addr, bus_wdata}, {p_addr, p_wdata});
            end
            if (pv_rd) chk("rd_hold", {bus_rd_en, bus_addr}, {1'b1, p_addr});
            if (pv_resp) chk("resp_hold", {resp_valid, resp_last, resp_data}, {1'b1, p_last, p_rdata});

            if (bus_wr_en && bus_ready) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexp: got addr %0h data %0h, required no write", bus_addr, bus_wdata);
                end else chk("write", {bus_addr, bus_wdata}, exp_wr.pop_front());
            end

            bus_rvalid <= 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus_rvalid <= 1'b1;
                    bus_rdata  <= rd_q.pop_front();
                    rd_pend    <= 1'b0;
                end else rd_cnt <= rd_cnt - 1;
            end
            if (bus_rd_en && bus_ready) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexp: got addr %0h, required no read", bus_addr);
                end else chk("read_addr", bus_addr, exp_rd.pop_front());
                if (!rd_mute) begin
                    rd_pend <= 1'b1;
                    rd_cnt  <= rd_lat;
                end
            end

            if (resp_valid && resp_ready) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexp: got %0h, required no response", resp_data);
                end else chk("resp", {resp_last, resp_data}, exp_resp.pop_front());
            end

            pv_wr   <= bus_wr_en && !bus_ready;
            pv_rd   <= bus_rd_en && !bus_ready;
            pv_resp <= resp_valid && !resp_ready;
            p_addr  <= bus_addr;
            p_wdata <= bus_wdata;
            p_rdata <= resp_data;
            p_last  <= resp_last;
        end
    end

    initial begin
        int p0;
        int c;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);

        // 1: WRITE N=3 at 0x100
        exp_wr.push_back({32'h100, 32'h11});
        exp_wr.push_back({32'h101, 32'h22});
        exp_wr.push_back({32'h102, 32'h33});
        push(0, 32'h1000_0003); push(0, 32'h100);
        push(0, 32'h11); push(0, 32'h22); push(1, 32'h33);
        wait_done("t1", 200);
        chk("t1_err", err_cnt, 0);

        // 2: READ N=2 at 0x200 with backpressure
        resp_toggle = 1'b1;
        rd_lat = 3;
        rd_q.push_back(32'hAA); rd_q.push_back(32'hBB);
        exp_rd.push_back(32'h200); exp_rd.push_back(32'h201);
        exp_resp.push_back({1'b0, 32'h2000_0002});
        exp_resp.push_back({1'b0, 32'hAA});
        exp_resp.push_back({1'b1, 32'hBB});
        push(0, 32'h2000_0002); push(1, 32'h200);
        wait_done("t2", 300);
        chk("t2_err", err_cnt, 0);
        resp_toggle = 1'b0;

        // 3: illegal opcode, LAST on third word
        p0 = pops;
        push(0, 32'h7000_0001); push(0, 32'h300); push(1, 32'h1234);
        wait_done("t3_drop", 200);
        chk("t3_pops", pops - p0, 3);
        chk("t3_err", err_cnt, 1);
        exp_wr.push_back({32'h300, 32'h55});
        push(0, 32'h1000_0001); push(0, 32'h300); push(1, 32'h55);
        wait_done("t3_next", 200);
        chk("t3_err_after", err_cnt, 1);

        // 4: WRITE N=4, LAST early on the third data word
        p0 = pops;
        exp_wr.push_back({32'h400, 32'hD0});
        exp_wr.push_back({32'h401, 32'hD1});
        push(0, 32'h1000_0004); push(0, 32'h400);
        push(0, 32'hD0); push(0, 32'hD1); push(1, 32'hD2);
        wait_done("t4", 200);
        chk("t4_pops", pops - p0, 5);
        chk("t4_err", err_cnt, 2);

        // 5: READ N=1 with no rvalid -> timeout data
        rd_mute = 1'b1;
        exp_rd.push_back(32'h500);
        exp_resp.push_back({1'b0, 32'h2000_0001});
        exp_resp.push_back({1'b1, 32'hDEAD_BEEF});
        push(0, 32'h2000_0001); push(1, 32'h500);
        wait_done("t5", 1000);
        chk("t5_err", err_cnt, 3);
        rd_mute = 1'b0;

        // 6: reset while a write is held off
        bus_ready = 1'b0;
        push(0, 32'h1000_0002); push(0, 32'h600); push(0, 32'h66); push(1, 32'h77);
        for (c = 0; c < 100; c++) begin
            if (bus_wr_en) break;
            tick(1);
        end
        if (c == 100) begin
            checks++;
            errors++;
            $display("FAIL t6_strobe: bus_wr_en never rose, required 1");
        end
        chk("t6_held_addr", {bus_wr_en, bus_addr, bus_wdata}, {1'b1, 32'h600, 32'h66});
        tick(3);
        rst = 1'b1;
        tick(1);
        check_zero("t6_rst");
        fwr = frd;
        tick(1);
        rst = 1'b0;
        bus_ready = 1'b1;
        tick(1);
        exp_wr.push_back({32'h700, 32'h71});
        exp_wr.push_back({32'h701, 32'h72});
        push(0, 32'h1000_0002); push(0, 32'h700); push(0, 32'h71); push(1, 32'h72);
        wait_done("t6_after", 200);
        chk("t6_err", err_cnt, 0);

        chk("left_wr", exp_wr.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_resp", exp_resp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
